// File: rtl/victim_fill_ctrl.sv
// victim_fill_ctrl: inserts L1 evictions into the victim cache.
// It looks the line up in the tag store and picks a destination way.
// A dirty displaced victim is written back to memory before the new line
// is installed. A dirty inserted line gets its dirty bit set afterwards.
// Optional feature macro: VC_FLUSH_EN adds flush_req/flush_done. A flush
// walks every way: it writes back valid+dirty lines and invalidates each way.
//
// Handshakes (ins_*, wb_*): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer that raises valid keeps it high,
// and keeps its payload stable, until that transfer. Only reset may drop it.
// ready may depend combinationally on state but never on the same-cycle valid.
module victim_fill_ctrl #(
  parameter int TAG_WIDTH  = 4,
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ins_valid,
  output logic                            ins_ready,
  input  logic [TAG_WIDTH-1:0]            ins_tag,
  input  logic [DATA_WIDTH-1:0]           ins_data,
  input  logic                            ins_dirty,
  output logic                            ts_lookup_en,
  output logic                            ts_write_en,
  output logic                            ts_read_en,
  output logic                            ts_valid_clear,
  output logic                            ts_dirty_set,
  output logic                            ts_dirty_clear,
  output logic [TAG_WIDTH-1:0]            ts_tag,
  output logic [$clog2(NUM_WAYS)-1:0]     ts_way,
  input  logic                            ts_hit,
  input  logic [$clog2(NUM_WAYS)-1:0]     ts_hit_way,
  input  logic [NUM_WAYS-1:0]             ts_valid_vector,
  input  logic [NUM_WAYS-1:0]             ts_dirty_vector,
  input  logic                            ts_valid_read,
  input  logic                            ts_dirty_read,
  output logic [$clog2(NUM_WAYS)-1:0]     dat_way,
  output logic                            dat_we,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] dat_wdata,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] dat_rdata,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [TAG_WIDTH-1:0]            wb_tag,
  output logic [DATA_WIDTH-1:0]           wb_data,
`ifdef VC_FLUSH_EN
  input  logic                            flush_req,
  output logic                            flush_done,
`endif
  output logic                            busy
);

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_DIRTY
`ifdef VC_FLUSH_EN
    , S_F_CHK,
    S_F_WB,
    S_F_INV
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [WAY_W-1:0]        rr_ptr_q;
  logic [TAG_WIDTH-1:0]    cap_tag_q;
  logic [DATA_WIDTH-1:0]   cap_data_q;
  logic                    cap_dirty_q;
  logic [WAY_W-1:0]        way_q;
  logic                    final_dirty_q;
  logic [TAG_WIDTH-1:0]    wb_tag_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;

  // Lookup-cycle decisions
  logic                    inv_found;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        lk_way;
  logic                    lk_evict;
  logic                    lk_wb;
  logic                    lk_final_dirty;
  logic                    accept;

`ifdef VC_FLUSH_EN
  logic [WAY_W-1:0]        idx_q;
  logic                    flush_done_q;
  assign flush_done = flush_done_q;
`else
  logic                    unused_rd;
  assign unused_rd = ts_valid_read ^ ts_dirty_read;
`endif

  assign busy    = (state_q != S_IDLE);
  assign wb_tag  = wb_tag_q;
  assign wb_data = wb_data_q;
  assign accept  = (state_q == S_IDLE) && ins_valid && ins_ready;

  // Pick the destination way: the hit way, else the lowest invalid way, else round robin
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!ts_valid_vector[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    lk_evict       = !ts_hit && !inv_found;
    lk_way         = ts_hit ? ts_hit_way : (inv_found ? inv_way : rr_ptr_q);
    lk_wb          = lk_evict && ts_dirty_vector[rr_ptr_q];
    lk_final_dirty = cap_dirty_q | (ts_hit & ts_dirty_vector[ts_hit_way]);
  end

  // Next-state and command outputs; everything idles at zero outside its owning state
  always_comb begin
    state_d        = state_q;
    ins_ready      = 1'b0;
    ts_lookup_en   = 1'b0;
    ts_write_en    = 1'b0;
    ts_read_en     = 1'b0;
    ts_valid_clear = 1'b0;
    ts_dirty_set   = 1'b0;
    ts_dirty_clear = 1'b0;
    ts_tag         = '0;
    ts_way         = '0;
    dat_way        = '0;
    dat_we         = 1'b0;
    dat_wdata      = '0;
    wb_valid       = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef VC_FLUSH_EN
        ins_ready = !rst && !flush_req;
        if (flush_req && !rst) begin
          state_d = S_F_CHK;
        end else if (ins_valid && ins_ready) begin
          state_d = S_LOOKUP;
        end
`else
        ins_ready = !rst;
        if (ins_valid && ins_ready) begin
          state_d = S_LOOKUP;
        end
`endif
      end
      S_LOOKUP: begin
        ts_lookup_en = 1'b1;
        ts_tag       = cap_tag_q;
        dat_way      = lk_way;
        state_d      = lk_wb ? S_WB : S_FILL;
      end
      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = S_FILL;
      end
      S_FILL: begin
        ts_write_en = 1'b1;
        ts_way      = way_q;
        ts_tag      = cap_tag_q;
        dat_we      = 1'b1;
        dat_way     = way_q;
        dat_wdata   = {cap_tag_q, cap_data_q};
        state_d     = final_dirty_q ? S_DIRTY : S_IDLE;
      end
      S_DIRTY: begin
        // The tag store lets a write win over dirty_set, so the dirty bit goes in its own cycle
        ts_dirty_set = 1'b1;
        ts_way       = way_q;
        state_d      = S_IDLE;
      end
`ifdef VC_FLUSH_EN
      S_F_CHK: begin
        ts_read_en = 1'b1;
        ts_way     = idx_q;
        dat_way    = idx_q;
        state_d    = (ts_valid_read && ts_dirty_read) ? S_F_WB : S_F_INV;
      end
      S_F_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = S_F_INV;
      end
      S_F_INV: begin
        ts_valid_clear = 1'b1;
        ts_way         = idx_q;
        state_d        = (idx_q == LAST_WAY) ? S_IDLE : S_F_CHK;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture, replacement pointer and writeback payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      cap_tag_q     <= '0;
      cap_data_q    <= '0;
      cap_dirty_q   <= 1'b0;
      way_q         <= '0;
      final_dirty_q <= 1'b0;
      wb_tag_q      <= '0;
      wb_data_q     <= '0;
`ifdef VC_FLUSH_EN
      idx_q         <= '0;
      flush_done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept && state_d == S_LOOKUP) begin
        cap_tag_q   <= ins_tag;
        cap_data_q  <= ins_data;
        cap_dirty_q <= ins_dirty;
      end
      if (state_q == S_LOOKUP) begin
        way_q         <= lk_way;
        final_dirty_q <= lk_final_dirty;
        wb_tag_q      <= dat_rdata[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
        wb_data_q     <= dat_rdata[DATA_WIDTH-1:0];
        if (lk_evict) begin
          rr_ptr_q <= (rr_ptr_q == LAST_WAY) ? '0 : rr_ptr_q + 1'b1;
        end
      end
`ifdef VC_FLUSH_EN
      flush_done_q <= 1'b0;
      if (state_q == S_IDLE && state_d == S_F_CHK) begin
        idx_q <= '0;
      end
      if (state_q == S_F_CHK) begin
        wb_tag_q  <= dat_rdata[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
        wb_data_q <= dat_rdata[DATA_WIDTH-1:0];
      end
      if (state_q == S_F_INV) begin
        if (idx_q == LAST_WAY) begin
          flush_done_q <= 1'b1;
          rr_ptr_q     <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_victim_fill_ctrl.sv
// tb_victim_fill_ctrl: randomized and directed bench for victim_fill_ctrl.
// The tag store and data array are behavioural memories that answer the DUT's commands.
// A reference model applies the replacement rules to its own copy of the cache.
// That model predicts way choice, writebacks, latency and final contents.
module tb_victim_fill_ctrl;
  localparam int TW = 4;
  localparam int NW = 4;
  localparam int DW = 32;
  localparam int WW = $clog2(NW);

  logic clk, rst;
  logic ins_valid, ins_ready, ins_dirty;
  logic [TW-1:0] ins_tag;
  logic [DW-1:0] ins_data;
  logic ts_lookup_en, ts_write_en, ts_read_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
  logic [TW-1:0] ts_tag;
  logic [WW-1:0] ts_way, ts_hit_way, dat_way;
  logic ts_hit, ts_valid_read, ts_dirty_read;
  logic [NW-1:0] ts_valid_vector, ts_dirty_vector;
  logic dat_we;
  logic [TW+DW-1:0] dat_wdata, dat_rdata;
  logic wb_valid, wb_ready;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic busy;
`ifdef VC_FLUSH_EN
  logic flush_req, flush_done;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [TW+DW-1:0] exp_q[$];

  // Environment memories (tag store + data array)
  logic env_init;
  logic env_valid[NW];
  logic env_dirty[NW];
  logic [TW-1:0] env_tag[NW];
  logic [TW+DW-1:0] env_dat[NW];

  // Reference model state
  logic ref_valid[NW];
  logic ref_dirty[NW];
  logic [TW-1:0] ref_tag[NW];
  logic [DW-1:0] ref_data[NW];
  int ref_rr;

  victim_fill_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag),
    .ins_data(ins_data), .ins_dirty(ins_dirty),
    .ts_lookup_en(ts_lookup_en), .ts_write_en(ts_write_en), .ts_read_en(ts_read_en),
    .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set),
    .ts_dirty_clear(ts_dirty_clear), .ts_tag(ts_tag), .ts_way(ts_way),
    .ts_hit(ts_hit), .ts_hit_way(ts_hit_way), .ts_valid_vector(ts_valid_vector),
    .ts_dirty_vector(ts_dirty_vector), .ts_valid_read(ts_valid_read),
    .ts_dirty_read(ts_dirty_read), .dat_way(dat_way), .dat_we(dat_we),
    .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
`ifdef VC_FLUSH_EN
    .flush_req(flush_req), .flush_done(flush_done),
`endif
    .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Tag store / data array responses
  always_comb begin
    ts_hit = 1'b0;
    ts_hit_way = '0;
    ts_valid_vector = '0;
    ts_dirty_vector = '0;
    ts_valid_read = 1'b0;
    ts_dirty_read = 1'b0;
    if (ts_lookup_en) begin
      for (int i = NW - 1; i >= 0; i--) begin
        ts_valid_vector[i] = env_valid[i];
        ts_dirty_vector[i] = env_dirty[i];
        if (env_valid[i] && env_tag[i] == ts_tag) begin
          ts_hit = 1'b1;
          ts_hit_way = WW'(i);
        end
      end
    end
    if (ts_read_en) begin
      ts_valid_read = env_valid[ts_way];
      ts_dirty_read = env_dirty[ts_way];
    end
  end
  assign dat_rdata = env_dat[dat_way];

  // Tag store / data array updates
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < NW; i++) begin
        env_valid[i] <= 1'b0;
        env_dirty[i] <= 1'b0;
        env_tag[i] <= '0;
        env_dat[i] <= '0;
      end
    end else begin
      if (ts_write_en) begin
        env_valid[ts_way] <= 1'b1;
        env_dirty[ts_way] <= 1'b0;
        env_tag[ts_way] <= ts_tag;
      end else if (ts_dirty_set) begin
        env_dirty[ts_way] <= 1'b1;
      end else if (ts_dirty_clear) begin
        env_dirty[ts_way] <= 1'b0;
      end
      if (ts_valid_clear) env_valid[ts_way] <= 1'b0;
      if (dat_we) env_dat[dat_way] <= dat_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    @(negedge clk);
    rst = 1'b1;
    env_init = 1'b1;
    ins_valid = 1'b0;
    wb_ready = 1'b0;
`ifdef VC_FLUSH_EN
    flush_req = 1'b0;
`endif
    #1;
    check_eq("rst_ins_ready", ins_ready, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    env_init = 1'b0;
    for (int i = 0; i < NW; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i] = '0;
      ref_data[i] = '0;
    end
    ref_rr = 0;
    #1;
    check_eq("idle_ins_ready", ins_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_wb_tag", wb_tag, 0);
    check_eq("idle_wb_data", wb_data, 0);
    check_eq("idle_strobes", {ts_lookup_en, ts_write_en, ts_read_en, ts_valid_clear,
                              ts_dirty_set, ts_dirty_clear, dat_we}, 0);
  endtask

  task automatic check_store();
    for (int i = 0; i < NW; i++) begin
      check_eq($sformatf("store_valid%0d", i), env_valid[i], ref_valid[i]);
      if (ref_valid[i]) begin
        check_eq($sformatf("store_dirty%0d", i), env_dirty[i], ref_dirty[i]);
        check_eq($sformatf("store_tag%0d", i), env_tag[i], ref_tag[i]);
        check_eq($sformatf("store_dat%0d", i), env_dat[i], {ref_tag[i], ref_data[i]});
      end
    end
  endtask

  // One eviction: predict from the reference, drive it, observe all commands until ready again
  task automatic do_insert(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                           input logic dirty, input int stall);
    int w, cycles, n_wr, n_ds, n_hs, n_wbc, st, exp_lat;
    logic hit, fd, exp_wb;
    bit done, waited;
    hit = 1'b0;
    w = -1;
    exp_wb = 1'b0;
    for (int i = 0; i < NW; i++)
      if (w < 0 && ref_valid[i] && ref_tag[i] == tag) begin
        hit = 1'b1;
        w = i;
      end
    if (!hit)
      for (int i = 0; i < NW; i++)
        if (w < 0 && !ref_valid[i]) w = i;
    if (w < 0) begin
      w = ref_rr;
      ref_rr = (ref_rr + 1) % NW;
      if (ref_dirty[w]) begin
        exp_wb = 1'b1;
        exp_q.push_back({ref_tag[w], ref_data[w]});
      end
    end
    fd = dirty | (hit & ref_dirty[w]);
    exp_lat = 3 + int'(fd) + (exp_wb ? stall + 1 : 0);

    @(negedge clk);
    waited = 1'b0;
    for (int k = 0; k < 20 && !ins_ready; k++) @(negedge clk);
    check_eq("pre_ins_ready", ins_ready, 1);
    ins_valid = 1'b1;
    ins_tag = tag;
    ins_data = data;
    ins_dirty = dirty;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    ins_tag = TW'($urandom);
    ins_data = $urandom;
    ins_dirty = 1'($urandom);

    cycles = 0; n_wr = 0; n_ds = 0; n_hs = 0; n_wbc = 0; st = stall; done = 1'b0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      wb_ready = 1'b0;
      if (ts_write_en) begin
        n_wr++;
        check_eq("fill_way", ts_way, w);
        check_eq("fill_tag", ts_tag, tag);
        check_eq("fill_dat_we", dat_we, 1);
        check_eq("fill_dat_way", dat_way, w);
        check_eq("fill_dat_wdata", dat_wdata, {tag, data});
      end
      if (ts_dirty_set) begin
        n_ds++;
        check_eq("dirty_way", ts_way, w);
      end
      if (wb_valid) begin
        n_wbc++;
        if (exp_q.size() == 0) begin
          check_eq("wb_unexpected", wb_valid, 0);
        end else begin
          check_eq("wb_tag", wb_tag, exp_q[0][TW+DW-1 -: TW]);
          check_eq("wb_data", wb_data, exp_q[0][DW-1:0]);
        end
        if (st == 0) begin
          wb_ready = 1'b1;
          n_hs++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          st--;
        end
      end
      if (ins_ready) done = 1'b1;
    end
    wb_ready = 1'b0;
    check_eq("done_in_budget", done, 1);
    check_eq("latency", cycles, exp_lat);
    check_eq("n_write", n_wr, 1);
    check_eq("n_dirty_set", n_ds, fd);
    check_eq("n_wb_handshake", n_hs, exp_wb);
    check_eq("wb_cycles", n_wbc, exp_wb ? stall + 1 : 0);
    check_eq("wb_pending", exp_q.size(), 0);
    exp_q.delete();
    check_eq("end_busy", busy, 0);
    ref_valid[w] = 1'b1;
    ref_tag[w] = tag;
    ref_data[w] = data;
    ref_dirty[w] = fd;
    check_store();
  endtask

  // Reset while a writeback is stalled: nothing written, writeback dropped
  task automatic reset_mid_wb();
    bit seen;
    clear_all();
    do_insert(4'h1, 32'h11, 1'b1, 0);
    do_insert(4'h2, 32'h22, 1'b0, 0);
    do_insert(4'h3, 32'h33, 1'b0, 0);
    do_insert(4'h4, 32'h44, 1'b0, 0);
    @(negedge clk);
    ins_valid = 1'b1;
    ins_tag = 4'h9;
    ins_data = 32'h99;
    ins_dirty = 1'b0;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      wb_ready = 1'b0;
      if (wb_valid) seen = 1'b1;
    end
    check_eq("rst_wb_seen", seen, 1);
    check_eq("rst_wb_tag", wb_tag, 4'h1);
    repeat (2) @(negedge clk);
    check_eq("rst_wb_held", wb_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_wb_valid", wb_valid, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_ins_ready", ins_ready, 0);
    check_eq("rst_mid_writes", {ts_write_en, dat_we}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", {ts_write_en, dat_we, ts_dirty_set, wb_valid}, 0);
    end
    ref_rr = 0;
    check_store();
    do_insert(4'h9, 32'h99, 1'b0, 1);
  endtask

`ifdef VC_FLUSH_EN
  task automatic do_flush();
    int n_clr, n_done, n_wbh, cycles;
    bit done;
    exp_q.delete();
    for (int i = 0; i < NW; i++)
      if (ref_valid[i] && ref_dirty[i]) exp_q.push_back({ref_tag[i], ref_data[i]});
    @(negedge clk);
    flush_req = 1'b1;
    #1;
    check_eq("flush_ins_ready", ins_ready, 0);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    n_clr = 0; n_done = 0; n_wbh = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      wb_ready = 1'b0;
      if (ts_valid_clear) begin
        check_eq("flush_clr_way", ts_way, n_clr);
        n_clr++;
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("flush_wb_unexpected", wb_valid, 0);
        end else begin
          check_eq("flush_wb_tag", wb_tag, exp_q[0][TW+DW-1 -: TW]);
          check_eq("flush_wb_data", wb_data, exp_q[0][DW-1:0]);
          if ($urandom_range(0, 1) == 1) begin
            wb_ready = 1'b1;
            n_wbh++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (flush_done) n_done++;
      if (ins_ready && n_done > 0) done = 1'b1;
    end
    wb_ready = 1'b0;
    @(negedge clk);
    check_eq("flush_done_pulse_end", flush_done, 0);
    check_eq("flush_finished", done, 1);
    check_eq("flush_clears", n_clr, NW);
    check_eq("flush_wb_count", n_wbh, 2);
    check_eq("flush_done_count", n_done, 1);
    check_eq("flush_wb_pending", exp_q.size(), 0);
    for (int i = 0; i < NW; i++) ref_valid[i] = 1'b0;
    ref_rr = 0;
    check_store();
  endtask
`endif

  // Stimulus
  initial begin
    rst = 1'b1;
    env_init = 1'b1;
    ins_valid = 1'b0;
    ins_tag = '0;
    ins_data = '0;
    ins_dirty = 1'b0;
    wb_ready = 1'b0;
`ifdef VC_FLUSH_EN
    flush_req = 1'b0;
`endif

    // First miss into an empty cache
    clear_all();
    do_insert(4'h3, 32'hA5A5_A5A5, 1'b0, 0);

    // Round-robin replacement once all ways are valid
    clear_all();
    for (int t = 1; t <= 4; t++) do_insert(TW'(t), 32'h100 + t, 1'b0, 0);
    do_insert(4'h5, 32'h105, 1'b0, 0);
    check_eq("rr_way0_tag5", env_tag[0], 4'h5);
    do_insert(4'h6, 32'h106, 1'b0, 0);
    check_eq("rr_way1_tag6", env_tag[1], 4'h6);

    // Dirty victim writeback with a 5-cycle stall
    clear_all();
    do_insert(4'h1, 32'h11, 1'b1, 0);
    do_insert(4'h2, 32'h22, 1'b0, 0);
    do_insert(4'h3, 32'h33, 1'b0, 0);
    do_insert(4'h4, 32'h44, 1'b0, 0);
    do_insert(4'h9, 32'h99, 1'b0, 5);

    // Dirty insert hitting a clean resident line
    clear_all();
    do_insert(4'h7, 32'h77, 1'b0, 0);
    do_insert(4'h8, 32'h88, 1'b0, 0);
    do_insert(4'h2, 32'h22, 1'b0, 0);
    do_insert(4'h2, 32'h2222, 1'b1, 0);
    check_eq("hit_dirty_way2", env_dirty[2], 1);

    reset_mid_wb();

    // Random traffic
    clear_all();
    for (int n = 0; n < 200; n++)
      do_insert(TW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3));

`ifdef VC_FLUSH_EN
    clear_all();
    do_insert(4'h1, 32'h1, 1'b0, 0);
    do_insert(4'h2, 32'h2, 1'b1, 0);
    do_insert(4'h3, 32'h3, 1'b0, 0);
    do_insert(4'h4, 32'h4, 1'b1, 0);
    do_flush();
    do_insert(4'hA, 32'hA, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/victim_fill_ctrl.md
Name: victim_fill_ctrl

Overview:
- Initiator-side controller for the victim cache tag store; drives its lookup, write, read, valid_clear and dirty_set/dirty_clear command interface.
- Accepts L1 evictions over a valid/ready channel and looks them up in the victim cache.
- Picks a destination way, writes back a dirty displaced victim to memory over a valid/ready channel, then installs the new line.
- Sits between the L1 eviction path, the tag store, the external victim data array and the memory writeback port.

Parameters:
TAG_WIDTH, 4, tag bits per line
NUM_WAYS, 4, victim cache ways (power of 2, >=2)
DATA_WIDTH, 32, line data bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ins_valid  in  1  L1 eviction request valid
ins_ready  out  1  controller can accept a request
ins_tag  in  TAG_WIDTH  evicted line tag
ins_data  in  DATA_WIDTH  evicted line data
ins_dirty  in  1  evicted line is dirty
ts_lookup_en  out  1  tag store lookup strobe
ts_write_en  out  1  tag store write (sets valid, clears dirty)
ts_read_en  out  1  tag store valid/dirty read
ts_valid_clear  out  1  invalidate ts_way
ts_dirty_set  out  1  set dirty on ts_way
ts_dirty_clear  out  1  clear dirty on ts_way (always 0 in this block)
ts_tag  out  TAG_WIDTH  tag for lookup/write
ts_way  out  $clog2(NUM_WAYS)  way index for write/read/clear/set
ts_hit  in  1  lookup hit
ts_hit_way  in  $clog2(NUM_WAYS)  hit way
ts_valid_vector  in  NUM_WAYS  per-way valid, qualified by lookup
ts_dirty_vector  in  NUM_WAYS  per-way dirty, qualified by lookup
ts_valid_read  in  1  valid of ts_way, qualified by read
ts_dirty_read  in  1  dirty of ts_way, qualified by read
dat_way  out  $clog2(NUM_WAYS)  data array index (combinational read)
dat_we  out  1  data array write
dat_wdata  out  TAG_WIDTH+DATA_WIDTH  {tag,data} written
dat_rdata  in  TAG_WIDTH+DATA_WIDTH  {tag,data} at dat_way, same cycle
wb_valid  out  1  writeback request valid
wb_ready  in  1  memory accepts writeback
wb_tag  out  TAG_WIDTH  writeback tag
wb_data  out  DATA_WIDTH  writeback data
busy  out  1  state != IDLE

Behaviour:
- Reset, async: state IDLE; rr_ptr=0; all capture registers 0; all outputs 0. ins_ready=0 while rst is high.
- Outside their owning state, all strobes are 0 and ts_tag/ts_way/dat_way are 0.
- IDLE: ins_ready=1.
  - On ins_valid&&ins_ready, capture tag, data and dirty; go LOOKUP.
- LOOKUP (1 cycle): ts_lookup_en=1, ts_tag=captured tag.
  - Hit: way=ts_hit_way; final_dirty=ts_dirty_vector[way] | cap_dirty; no writeback.
  - Miss, some way invalid: way=lowest-index invalid way; rr_ptr unchanged.
  - Miss, all ways valid: way=rr_ptr; rr_ptr <= rr_ptr+1, wrapping NUM_WAYS-1 -> 0.
  - dat_way=way (combinational) during LOOKUP.
  - On exit, register dat_rdata into wb_tag/wb_data.
  - Next state WB if miss && victim valid && victim dirty, else FILL.
- WB: wb_valid=1; wb_tag/wb_data held stable until wb_valid&&wb_ready. On handshake go FILL.
  - wb_ready asserted on the first WB cycle completes in 1 cycle.
  - wb_valid never drops without a handshake, except on reset.
- FILL (1 cycle): ts_write_en=1, ts_way=way, ts_tag=cap_tag; dat_we=1, dat_way=way, dat_wdata={cap_tag,cap_data}.
  - Next state DIRTY if final_dirty (miss: final_dirty=cap_dirty), else IDLE.
- DIRTY (1 cycle): ts_dirty_set=1, ts_way=way; go IDLE.
  - DIRTY is a separate cycle because the tag store gives write priority over dirty_set.
- Latency, accept cycle to ins_ready high again:
  - clean miss or clean hit: 3 cycles
  - dirty insert: 4 cycles
  - plus N+1 cycles when writeback is stalled N cycles
- Only one request in flight; ins_ready low in every non-IDLE state.
- Reset mid-operation aborts the request: no tag store or data array write; any pending writeback is dropped.
- More than one hit bit set is a tag store concern; ts_hit_way is used as given.

Optional Feature:
- Macro VC_FLUSH_EN.
- Defined: adds ports flush_req (in, 1) and flush_done (out, 1).
  - In IDLE, flush_req has priority over ins_valid; ins_ready=0 while flush_req is high.
  - Flush walks idx 0..NUM_WAYS-1 through F_CHK -> F_WB -> F_INV.
  - F_CHK: ts_read_en=1, ts_way=idx, dat_way=idx; capture dat_rdata; go F_WB if ts_valid_read&&ts_dirty_read, else F_INV.
  - F_WB: same handshake rules as WB.
  - F_INV: ts_valid_clear=1, ts_way=idx.
  - After the last way: flush_done pulses 1 cycle, rr_ptr=0, return to IDLE.
- Not defined: ports absent; no flush states.

Test Plan:
- After reset, insert tag 0x3, data 0xA5A5A5A5, clean -> miss, FILL to way 0, ins_ready high 3 cycles after accept, no wb_valid.
- Fill ways 0-3 with tags 1-4, then insert tag 5 clean -> way 0 (rr_ptr=0) replaced, rr_ptr=1; next tag 6 -> way 1.
- Way 0 holds dirty tag 0x1, data 0x11, all ways valid; insert tag 0x9 -> wb_valid with wb_tag=0x1, wb_data=0x11; wb_ready held low 5 cycles -> outputs stable, then FILL way 0.
- Insert tag 0x2 dirty when 0x2 resident clean in way 2 -> hit, FILL then DIRTY with ts_way=2, no writeback.
- rst asserted during WB stall -> wb_valid=0 immediately, state IDLE, no ts_write_en or dat_we.
- VC_FLUSH_EN: ways 1 and 3 dirty, flush_req=1 -> two writebacks (ways 1, 3), four ts_valid_clear, flush_done single pulse.
